mips_mc_core: RTL and testbench

MIPS_MC_CORE -- requirements
Module: mips_mc_core

---
 rtl/mips_mc_core_if.sv | 21 ++
 rtl/mips_mc_core.sv | 197 +++++++++++++++++++
 tb/tb_mips_mc_core.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_core_if.sv
// rtl/mips_mc_core_if.sv - shared instruction/data memory port of the multi-cycle core
interface mips_mc_core_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mips_mc_core.sv
// rtl/mips_mc_core.sv - multi-cycle MIPS subset core on a single shared memory port
// FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with a 32x32 register file.
module mips_mc_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ADDR_W          = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  mips_mc_core_if.master bus,
  output logic           halted,
  output logic           illegal,
  output logic [31:0]    pc_out
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
  logic        illegal_q, illegal_d;
  logic        rst_hold_q;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr_full, mem_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext;
  logic        legal;
  state_t      fault_state;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign fault_state = HALT_ON_ILLEGAL ? HALT : FETCH;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = funct inside {FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_d         = alu_q;
    mdr_d         = mdr_q;
    illegal_d     = illegal_q;
    rf_we         = 1'b0;
    rf_waddr      = rt;
    rf_wdata      = alu_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_full = pc_q;
    mem_wdata     = b_q;
    case (state_q)
      FETCH: begin
        // Request is held off for the first cycle out of reset.
        if (!rst_hold_q) begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_d    = bus.mem_rdata;
            pc_d    = pc_q + 32'd4;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        a_d   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
        b_d   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
        alu_d = pc_q + (imm_sext << 2);
        if (legal) begin
          state_d = EXEC;
        end else begin
          state_d   = fault_state;
          illegal_d = illegal_q | HALT_ON_ILLEGAL;
        end
      end
      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OP_RTYPE: begin
            state_d = WB;
            case (funct)
              FN_ADD: alu_d = a_q + b_q;
              FN_SUB: alu_d = a_q - b_q;
              FN_AND: alu_d = a_q & b_q;
              FN_OR:  alu_d = a_q | b_q;
              FN_SLT: alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
              FN_SLL: alu_d = b_q << shamt;
              FN_SRL: alu_d = b_q >> shamt;
              FN_JR: begin
                pc_d    = a_q;
                state_d = FETCH;
              end
              default: alu_d = alu_q;
            endcase
          end
          OP_ADDI: begin
            alu_d   = a_q + imm_sext;
            state_d = WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_sext;
            state_d = MEM;
          end
          OP_BEQ: if (a_q == b_q) pc_d = alu_q;
          OP_BNE: if (a_q != b_q) pc_d = alu_q;
          OP_J:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        // A misaligned address never reaches the bus.
        if (alu_q[1:0] != 2'b00) begin
          state_d   = fault_state;
          illegal_d = illegal_q | HALT_ON_ILLEGAL;
        end else begin
          mem_req       = 1'b1;
          mem_we        = (opcode == OP_SW);
          mem_addr_full = alu_q;
          if (bus.mem_ready) begin
            if (opcode == OP_SW) begin
              state_d = FETCH;
            end else begin
              mdr_d   = bus.mem_rdata;
              state_d = WB;
            end
          end
        end
      end
      WB: begin
        rf_we   = 1'b1;
        state_d = FETCH;
        if (opcode == OP_RTYPE) begin
          rf_waddr = rd;
        end else if (opcode == OP_LW) begin
          rf_wdata = mdr_q;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      illegal_q  <= 1'b0;
      rst_hold_q <= 1'b1;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      illegal_q  <= illegal_d;
      rst_hold_q <= 1'b0;
      if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr_full[ADDR_W-1:0];
  assign bus.mem_wdata = mem_wdata;
  assign halted        = (state_q == HALT);
  assign illegal       = illegal_q;
  assign pc_out        = pc_q;
endmodule

// File: tb/tb_mips_mc_core.sv
// tb/tb_mips_mc_core.sv - self-checking bench for mips_mc_core
// Memory responder with configurable waits plus an ISA-level reference model.
module tb_mips_mc_core;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ILL = 32'hFC00_0000;
  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic halted, illegal;
  logic [31:0] pc_out;

  mips_mc_core_if #(.ADDR_W(32)) bus ();

  mips_mc_core #(.RESET_PC(RESET_PC), .ADDR_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus.master),
    .halted(halted), .illegal(illegal), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mem [0:1023];
  int wait_n = 0;
  bit rand_waits = 0;
  bit stall_we = 0;
  int total_waits = 0;
  int misaligned_reqs = 0;
  logic [31:0] st_addr_q[$], st_data_q[$];

  bit pending = 0;
  int wcnt, cur_wait;
  logic [31:0] h_addr, h_wdata;
  logic h_we;

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 || bus.mem_req !== 1'b1) begin
        pending = 0;
        bus.mem_ready = 1'b0;
      end else begin
        if (!pending) begin
          pending = 1; wcnt = 0;
          cur_wait = rand_waits ? int'($urandom_range(0, 2)) : wait_n;
          h_addr = bus.mem_addr; h_we = bus.mem_we; h_wdata = bus.mem_wdata;
          if (bus.mem_addr[1:0] != 2'b00) misaligned_reqs++;
        end else begin
          wcnt++;
          n_checks++;
          if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {h_addr, h_we, h_wdata}) begin
            n_fail++;
            $display("FAIL req_stable: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, h_addr, h_we, h_wdata);
          end
        end
        if (wcnt >= cur_wait && !(h_we && stall_we)) begin
          bus.mem_ready = 1'b1; pending = 0; total_waits += cur_wait;
          if (h_we) begin
            mem[h_addr[11:2]] = h_wdata;
            st_addr_q.push_back(h_addr); st_data_q.push_back(h_wdata);
          end else begin
            bus.mem_rdata = mem[h_addr[11:2]];
          end
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    total_waits = 0; misaligned_reqs = 0;
    st_addr_q.delete(); st_data_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_first_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) ok = 1;
    end
  endtask

  task automatic count_to_halt(output int k);
    bit done;
    done = 0; k = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      k++;
      if (halted === 1'b1) done = 1;
    end
    if (!done) k = -1;
  endtask

  task automatic test_illegal_opcode();
    bit ok; int k;
    clear_mem(); wait_n = 0; rand_waits = 0;
    mem[0] = ILL;
    do_reset();
    wait_first_req(ok);
    count_to_halt(k);
    n_checks++;
    if (!ok || k !== 2) begin n_fail++; $display("FAIL illegal_halt_cycles: got %0d (req seen %0d), required 2", k, ok); end
    n_checks++;
    if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b, required 1", illegal); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mem_req !== 1'b0 || halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold: mem_req=%b halted=%b, required 0/1", bus.mem_req, halted);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.mem_req, halted, illegal} !== 3'b000 || pc_out !== RESET_PC) begin
      n_fail++; $display("FAIL reset_state: req/halted/illegal=%b pc=%h, required 000 pc=%h",
                         {bus.mem_req, halted, illegal}, pc_out, RESET_PC);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL first_fetch: req=%b we=%b addr=%h, required 1 0 %h",
                         bus.mem_req, bus.mem_we, bus.mem_addr, RESET_PC);
    end
  endtask

  task automatic test_program();
    bit ok; int k;
    clear_mem(); wait_n = 0; rand_waits = 0;
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    mem[3] = ILL;
    do_reset();
    wait_first_req(ok);
    repeat (11) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || dut.rf_q[3] !== 32'd0) begin n_fail++; $display("FAIL prog_r3_early: got %h, required 0", dut.rf_q[3]); end
    @(posedge clk); #1;
    n_checks++;
    if (dut.rf_q[3] !== 32'd12 || pc_out !== 32'd12) begin
      n_fail++; $display("FAIL prog_r3_12cyc: r3=%0d pc=%h, required 12 and 0000000c", dut.rf_q[3], pc_out);
    end
    n_checks++;
    if (dut.rf_q[1] !== 32'd5 || dut.rf_q[2] !== 32'd7) begin
      n_fail++; $display("FAIL prog_r1_r2: got %0d %0d, required 5 7", dut.rf_q[1], dut.rf_q[2]);
    end
    count_to_halt(k);
    n_checks++;
    if (k !== 2) begin n_fail++; $display("FAIL prog_halt: got %0d cycles, required 2", k); end
  endtask

  task automatic test_sw_lw_waits();
    bit ok; int k;
    clear_mem(); wait_n = 2; rand_waits = 0;
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd3, 16'd12);
    mem[1] = enc_i(OP_SW, 5'd0, 5'd3, 16'h0010);
    mem[2] = enc_i(OP_LW, 5'd0, 5'd4, 16'h0010);
    mem[3] = ILL;
    mem[4] = 32'hDEAD_BEEF;
    do_reset();
    wait_first_req(ok);
    count_to_halt(k);
    n_checks++;
    if (!ok || k !== (4 + 4 + 5 + 4 * 2 + 2 * 2 + 2)) begin
      n_fail++; $display("FAIL swlw_cycles: got %0d, required %0d", k, 4 + 4 + 5 + 12 + 2);
    end
    n_checks++;
    if (st_addr_q.size() != 1 || st_addr_q[0] !== 32'h10 || st_data_q[0] !== 32'd12) begin
      n_fail++; $display("FAIL swlw_store: count=%0d, required one store of 12 at 00000010", st_addr_q.size());
    end
    n_checks++;
    if (dut.rf_q[4] !== 32'd12) begin n_fail++; $display("FAIL swlw_r4: got %h, required 0000000c", dut.rf_q[4]); end
    wait_n = 0;
  endtask

  task automatic test_branch_loop();
    bit ok; bit any_nz; logic [31:0] exp_pc;
    clear_mem(); wait_n = 0; rand_waits = 0;
    mem[0] = {OP_J, 26'd8};
    mem[8] = enc_i(OP_BEQ, 5'd1, 5'd1, 16'hFFFF);
    do_reset();
    wait_first_req(ok);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      exp_pc = (c % 3 == 0) ? 32'h20 : 32'h24;
      n_checks++;
      if (!ok || pc_out !== exp_pc) begin
        n_fail++; $display("FAIL loop_pc[%0d]: got %h, required %h", c, pc_out, exp_pc);
      end
      @(negedge clk);
    end
    any_nz = 0;
    for (int r = 0; r < 32; r++) if (dut.rf_q[r] !== 32'd0) any_nz = 1;
    n_checks++;
    if (any_nz || st_addr_q.size() != 0) begin
      n_fail++; $display("FAIL loop_no_write: regs_changed=%b stores=%0d, required 0 0", any_nz, st_addr_q.size());
    end
  endtask

  task automatic test_misaligned();
    bit ok; int k;
    clear_mem(); wait_n = 0; rand_waits = 0;
    mem[0] = enc_i(OP_LW, 5'd0, 5'd5, 16'h0001);
    do_reset();
    wait_first_req(ok);
    count_to_halt(k);
    n_checks++;
    if (!ok || k !== 4 || illegal !== 1'b1) begin
      n_fail++; $display("FAIL misaligned_halt: cycles=%0d illegal=%b, required 4 1", k, illegal);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (misaligned_reqs != 0 || bus.mem_req !== 1'b0 || dut.rf_q[5] !== 32'd0) begin
      n_fail++; $display("FAIL misaligned_no_req: reqs=%0d mem_req=%b r5=%h, required 0 0 0",
                         misaligned_reqs, bus.mem_req, dut.rf_q[5]);
    end
  endtask

  task automatic test_reset_mid_sw();
    bit seen; int k;
    clear_mem(); wait_n = 0; rand_waits = 0; stall_we = 1;
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd3, 16'd12);
    mem[1] = enc_i(OP_SW, 5'd0, 5'd3, 16'h0040);
    mem[16] = 32'h1111_2222;
    do_reset();
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'd12) begin
      n_fail++; $display("FAIL stall_sw_req: seen=%b addr=%h data=%h, required 1 00000040 0000000c",
                         seen, bus.mem_addr, bus.mem_wdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9);
    mem[1] = ILL;
    @(posedge clk); #1;
    n_checks++;
    if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL abandon_req: mem_req=%b, required 0", bus.mem_req); end
    @(negedge clk);
    reset = 1'b1; stall_we = 0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL restart_fetch: req=%b addr=%h, required 1 %h", bus.mem_req, bus.mem_addr, RESET_PC);
    end
    count_to_halt(k);
    n_checks++;
    if (k !== 6 || dut.rf_q[0] !== 32'd0 || dut.rf_q[3] !== 32'd0) begin
      n_fail++; $display("FAIL r0_discard: cycles=%0d r0=%h r3=%h, required 6 0 0", k, dut.rf_q[0], dut.rf_q[3]);
    end
    n_checks++;
    if (st_addr_q.size() != 0 || mem[16] !== 32'h1111_2222) begin
      n_fail++; $display("FAIL abandon_store: stores=%0d mem=%h, required 0 11112222", st_addr_q.size(), mem[16]);
    end
  endtask

  task automatic test_random_programs();
    logic [31:0] prog [0:31];
    logic [31:0] mr [32];
    logic [31:0] mdm [0:1023];
    logic [31:0] ea_q[$], ed_q[$];
    logic [5:0]  fns [7];
    logic [31:0] ins, pc, npc, va, vb, res, off;
    logic [5:0] op;
    int n, lat, kind, k, tgt;
    bit ok, run;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
    rand_waits = 1; stall_we = 0;
    for (int it = 0; it < 4; it++) begin
      n = 16;
      clear_mem();
      for (int i = 512; i < 1024; i++) mem[i] = $urandom;
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 9);
        tgt = i + 1 + int'($urandom_range(0, (n - 1 - i) < 2 ? (n - 1 - i) : 2));
        case (kind)
          0, 1, 8: prog[i] = enc_i(OP_ADDI, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
          2, 9: begin
            k = $urandom_range(0, 6);
            prog[i] = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            (k >= 5) ? 5'($urandom) : 5'd0, fns[k]);
          end
          3: prog[i] = enc_i(OP_SW, 5'd0, 5'($urandom_range(0, 7)), 16'(32'h800 + 4 * $urandom_range(0, 511)));
          4: prog[i] = enc_i(OP_LW, 5'd0, 5'($urandom_range(0, 7)), 16'(32'h800 + 4 * $urandom_range(0, 511)));
          5: prog[i] = enc_i(OP_BEQ, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'(tgt - i - 1));
          6: prog[i] = enc_i(OP_BNE, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'(tgt - i - 1));
          default: prog[i] = {OP_J, 26'(tgt)};
        endcase
        mem[i] = prog[i];
      end
      prog[n] = ILL; mem[n] = ILL;
      for (int i = 0; i < 1024; i++) mdm[i] = mem[i];
      for (int r = 0; r < 32; r++) mr[r] = 32'd0;
      ea_q.delete(); ed_q.delete();
      pc = RESET_PC; lat = 0; run = 1;
      while (run) begin
        ins = prog[pc[6:2]]; op = ins[31:26];
        va = mr[ins[25:21]]; vb = mr[ins[20:16]];
        off = {{16{ins[15]}}, ins[15:0]};
        npc = pc + 32'd4;
        if (op == 6'h00) begin
          case (ins[5:0])
            6'h20: res = va + vb;
            6'h22: res = va - vb;
            6'h24: res = va & vb;
            6'h25: res = va | vb;
            6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            6'h00: res = vb << ins[10:6];
            default: res = vb >> ins[10:6];
          endcase
          if (ins[15:11] != 0) mr[ins[15:11]] = res;
          lat += 4;
        end else if (op == OP_ADDI) begin
          if (ins[20:16] != 0) mr[ins[20:16]] = va + off;
          lat += 4;
        end else if (op == OP_SW) begin
          mdm[(va + off) >> 2] = vb; ea_q.push_back(va + off); ed_q.push_back(vb);
          lat += 4;
        end else if (op == OP_LW) begin
          if (ins[20:16] != 0) mr[ins[20:16]] = mdm[(va + off) >> 2];
          lat += 5;
        end else if (op == OP_BEQ || op == OP_BNE) begin
          if ((va == vb) == (op == OP_BEQ)) npc = npc + (off * 4);
          lat += 3;
        end else if (op == OP_J) begin
          npc = {npc[31:28], ins[25:0], 2'b00};
          lat += 3;
        end else begin
          run = 0;
        end
        pc = npc;
      end
      do_reset();
      wait_first_req(ok);
      count_to_halt(k);
      n_checks++;
      if (!ok || k !== lat + total_waits + 2) begin
        n_fail++; $display("FAIL rnd%0d_cycles: got %0d, required %0d", it, k, lat + total_waits + 2);
      end
      n_checks++;
      if (pc_out !== pc || illegal !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_pc: got %h illegal=%b, required %h 1", it, pc_out, illegal, pc);
      end
      for (int r = 0; r < 8; r++) begin
        n_checks++;
        if (dut.rf_q[r] !== mr[r]) begin
          n_fail++; $display("FAIL rnd%0d_r%0d: got %h, required %h", it, r, dut.rf_q[r], mr[r]);
        end
      end
      n_checks++;
      if (st_addr_q.size() != ea_q.size()) begin
        n_fail++; $display("FAIL rnd%0d_store_count: got %0d, required %0d", it, st_addr_q.size(), ea_q.size());
      end else begin
        for (int s = 0; s < ea_q.size(); s++) begin
          n_checks++;
          if (st_addr_q[s] !== ea_q[s] || st_data_q[s] !== ed_q[s]) begin
            n_fail++; $display("FAIL rnd%0d_store%0d: got %h@%h, required %h@%h",
                               it, s, st_data_q[s], st_addr_q[s], ed_q[s], ea_q[s]);
          end
        end
      end
    end
    rand_waits = 0;
  endtask

  initial begin
    test_illegal_opcode();
    test_reset();
    test_program();
    test_sw_lw_waits();
    test_branch_loop();
    test_misaligned();
    test_reset_mid_sw();
    test_random_programs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
